uart_rx_buffer: RTL and testbench



---
 rtl/uart_rx_buffer_pkg.sv | 17 +
 rtl/uart_rx_buffer_if.sv | 22 ++
 rtl/uart_rx_buffer_fifo.sv | 64 ++++++
 rtl/uart_rx_buffer.sv | 145 ++++++++++++++
 tb/tb_uart_rx_buffer.sv | 345 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_buffer_pkg.sv
// rtl/uart_rx_buffer_pkg.sv - UART register map and receive poll-state encodings
package uart_rx_buffer_pkg;

  localparam logic [31:0] UART_RX_FIFO_ADDR = 32'h0000_0000;
  localparam logic [31:0] UART_TX_FIFO_ADDR = 32'h0000_0004;
  localparam logic [31:0] UART_STAT_ADDR    = 32'h0000_0008;

  localparam int STAT_RX_VALID_BIT = 0;
  localparam int RESP_ERR_BIT      = 1;

  typedef enum logic [1:0] {
    POLL_IDLE = 2'd0,
    POLL_STAT = 2'd1,
    POLL_DATA = 2'd2
  } poll_state_e;

endpackage

// File: rtl/uart_rx_buffer_if.sv
// rtl/uart_rx_buffer_if.sv - AXI4-Lite read channel between the receive buffer and the UART
interface uart_rx_buffer_if;

  logic [31:0] uart_araddr;
  logic        uart_arvalid;
  logic        uart_arready;
  logic [31:0] uart_rdata;
  logic [1:0]  uart_rresp;
  logic        uart_rvalid;
  logic        uart_rready;

  modport master (
    output uart_araddr, uart_arvalid, uart_rready,
    input  uart_arready, uart_rdata, uart_rresp, uart_rvalid
  );

  modport slave (
    input  uart_araddr, uart_arvalid, uart_rready,
    output uart_arready, uart_rdata, uart_rresp, uart_rvalid
  );

endinterface

// File: rtl/uart_rx_buffer_fifo.sv
// rtl/uart_rx_buffer_fifo.sv - circular word FIFO; pointers wrap naturally, count 0..DEPTH
module word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/uart_rx_buffer.sv
// rtl/uart_rx_buffer.sv - polls the UART over AXI4-Lite, packs RX bytes into words, serves core reads
module uart_rx_buffer
  import uart_rx_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             renable,
  output logic             rdone,
  output logic [31:0]      rdata,
  uart_rx_buffer_if.master uart
);

  localparam int CW = $clog2(DEPTH) + 1;

  poll_state_e state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic [31:0] assemble_q, assemble_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic        pending_q, pending_d;
  logic        rdone_q, rdone_d;
  logic [31:0] rdata_q, rdata_d;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;

  logic unused_bits;
  assign unused_bits = ^{uart.uart_rdata[31:8], uart.uart_rresp[0], fifo_full};

  word_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data (assemble_d),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // A new poll only starts with a free slot, so the single push it can cause never overflows.
  always_comb begin
    state_d    = state_q;
    araddr_d   = araddr_q;
    arvalid_d  = arvalid_q;
    rready_d   = rready_q;
    assemble_d = assemble_q;
    byte_cnt_d = byte_cnt_q;
    fifo_push  = 1'b0;
    if (arvalid_q && uart.uart_arready) begin
      arvalid_d = 1'b0;
    end
    case (state_q)
      POLL_IDLE: begin
        if (fifo_count < CW'(DEPTH)) begin
          araddr_d  = UART_STAT_ADDR;
          arvalid_d = 1'b1;
          rready_d  = 1'b1;
          state_d   = POLL_STAT;
        end
      end
      POLL_STAT: begin
        if (rready_q && uart.uart_rvalid) begin
          rready_d = 1'b0;
          if (uart.uart_rresp[RESP_ERR_BIT]) begin
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
          end else if (uart.uart_rdata[STAT_RX_VALID_BIT]) begin
            araddr_d  = UART_RX_FIFO_ADDR;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            state_d   = POLL_DATA;
          end else begin
            state_d = POLL_IDLE;
          end
        end
      end
      POLL_DATA: begin
        if (rready_q && uart.uart_rvalid) begin
          rready_d = 1'b0;
          if (uart.uart_rresp[RESP_ERR_BIT]) begin
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
          end else begin
            assemble_d = {uart.uart_rdata[7:0], assemble_q[31:8]};
            byte_cnt_d = byte_cnt_q + 2'd1;
            fifo_push  = (byte_cnt_q == 2'd3);
            state_d    = POLL_IDLE;
          end
        end
      end
      default: state_d = POLL_IDLE;
    endcase
  end

  // Requests do not queue: renable while one is pending is dropped.
  always_comb begin
    pending_d = pending_q | renable;
    rdone_d   = 1'b0;
    rdata_d   = rdata_q;
    fifo_pop  = 1'b0;
    if (pending_q && !fifo_empty) begin
      fifo_pop  = 1'b1;
      rdata_d   = fifo_head;
      rdone_d   = 1'b1;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= POLL_IDLE;
      araddr_q   <= UART_STAT_ADDR;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      assemble_q <= '0;
      byte_cnt_q <= '0;
      pending_q  <= 1'b0;
      rdone_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      araddr_q   <= araddr_d;
      arvalid_q  <= arvalid_d;
      rready_q   <= rready_d;
      assemble_q <= assemble_d;
      byte_cnt_q <= byte_cnt_d;
      pending_q  <= pending_d;
      rdone_q    <= rdone_d;
      rdata_q    <= rdata_d;
    end
  end

  assign uart.uart_araddr  = araddr_q;
  assign uart.uart_arvalid = arvalid_q;
  assign uart.uart_rready  = rready_q;
  assign rdone             = rdone_q;
  assign rdata             = rdata_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb/tb_uart_rx_buffer.sv - self-checking bench for uart_rx_buffer with a UART read-channel model
module tb_uart_rx_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        renable;
  logic        rdone;
  logic [31:0] rdata;

  always #5 clk = ~clk;

  uart_rx_buffer_if bus ();

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .renable (renable),
    .rdone   (rdone),
    .rdata   (rdata),
    .uart    (bus)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [31:0] exp;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0]  rx_bytes [$];
  logic [31:0] sb [$];

  int stat_reads = 0, data_reads = 0, data_ok = 0;
  int rdone_cnt = 0, arvalid_cnt = 0, rdone_cyc = 0, last_data_cyc = 0;
  int stat_err = 0, data_err = 0, err_cyc = 0, after_err_gap = -1;
  logic [31:0] after_err_addr = '1;
  bit slow = 1'b0;
  bit watch_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // UART slave: state is advanced at each negedge from what was driven before the last posedge.
  bit          have_req = 1'b0, p_rstn = 1'b0, p_ar_hs = 1'b0, p_r_hs = 1'b0, p_err = 1'b0, cur_err;
  logic [31:0] req_addr = '0, p_araddr = '0, p_addr = '0, rnd;
  logic [7:0]  cur_byte;

  initial begin
    bus.uart_arready = 1'b0;
    bus.uart_rvalid  = 1'b0;
    bus.uart_rdata   = '0;
    bus.uart_rresp   = '0;
    forever begin
      @(negedge clk);
      if (!p_rstn) begin
        have_req = 1'b0;
      end else begin
        if (p_r_hs) begin
          have_req = 1'b0;
          if (p_err) begin
            if (p_addr == 32'h8) begin
              stat_err--;
              watch_err = 1'b1;
              err_cyc = cyc;
            end else begin
              data_err--;
            end
          end else if (p_addr == 32'h0 && rx_bytes.size() > 0) begin
            void'(rx_bytes.pop_front());
            data_ok++;
            last_data_cyc = cyc;
          end
        end
        if (p_ar_hs) begin
          have_req = 1'b1;
          req_addr = p_araddr;
          if (p_araddr == 32'h8) stat_reads++;
          else data_reads++;
          if (watch_err) begin
            after_err_addr = p_araddr;
            after_err_gap = cyc - err_cyc;
            watch_err = 1'b0;
          end
        end
      end
      rnd = $urandom();
      cur_err = 1'b0;
      bus.uart_arready = bus.uart_arvalid && !have_req && !(slow && $urandom_range(0, 1) == 0);
      bus.uart_rvalid  = have_req && !(slow && $urandom_range(0, 2) == 0);
      bus.uart_rdata   = rnd;
      if (have_req) begin
        if (req_addr == 32'h8) begin
          bus.uart_rdata = {rnd[31:1], rx_bytes.size() != 0};
          cur_err = (stat_err > 0);
        end else begin
          cur_byte = (rx_bytes.size() != 0) ? rx_bytes[0] : 8'h00;
          bus.uart_rdata = {rnd[31:8], cur_byte};
          cur_err = (data_err > 0);
        end
      end
      bus.uart_rresp = {cur_err, rnd[0]};
      p_rstn   = rstn;
      p_ar_hs  = bus.uart_arvalid && bus.uart_arready;
      p_araddr = bus.uart_araddr;
      p_r_hs   = bus.uart_rvalid && bus.uart_rready;
      p_err    = cur_err;
      p_addr   = req_addr;
    end
  end

  bit prev_rdone = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.uart_arvalid) arvalid_cnt++;
      if (rdone) begin
        rdone_cnt++;
        rdone_cyc = cyc;
        chk("rdone_not_back_to_back", {31'b0, prev_rdone}, 32'h0);
        if (sb.size() == 0) begin
          chk("rdone_expected", 32'h0, 32'h1);
        end else begin
          chk("rdone_word", rdata, sb.pop_front());
        end
      end
      prev_rdone = rdone;
      #3;
      if (dut.fifo_push && dut.fifo_full) begin
        failures++;
        $display("FAIL push_when_full: push asserted with FIFO full at cycle %0d", cyc);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_renable();
    renable = 1'b1;
    tick();
    renable = 1'b0;
  endtask

  task automatic offer(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    rx_bytes.push_back(b0);
    rx_bytes.push_back(b1);
    rx_bytes.push_back(b2);
    rx_bytes.push_back(b3);
  endtask

  task automatic wait_drain(input string name, input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk(name, sb.size(), 32'h0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdone"}, {31'b0, rdone}, 32'h0);
    chk({tag, "_rdata"}, rdata, 32'h0);
    chk({tag, "_arvalid"}, {31'b0, bus.uart_arvalid}, 32'h0);
    chk({tag, "_rready"}, {31'b0, bus.uart_rready}, 32'h0);
    chk({tag, "_araddr"}, bus.uart_araddr, 32'h8);
  endtask

  vec_t vecs [5];
  int r0, r1, s0, d0, ok0, a0, n;
  logic [7:0]  bv;
  logic [31:0] w;

  initial begin
    vecs[0] = '{8'h78, 8'h56, 8'h34, 8'h12, 32'h1234_5678};
    vecs[1] = '{8'h01, 8'h00, 8'h00, 8'h80, 32'h8000_0001};
    vecs[2] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF};
    vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 32'h0000_0000};
    vecs[4] = '{8'hA5, 8'h3C, 8'hC3, 8'h5A, 32'h5AC3_3CA5};

    rstn = 1'b0;
    renable = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    rstn = 1'b1;

    n = 0;
    while (!bus.uart_arvalid && n < 4) begin
      tick();
      n++;
    end
    chk("first_poll_arvalid", {31'b0, bus.uart_arvalid}, 32'h1);
    chk("first_poll_araddr", bus.uart_araddr, 32'h8);

    // Table of words under a randomly stalling UART.
    slow = 1'b1;
    for (int i = 0; i < 5; i++) begin
      offer(vecs[i].b0, vecs[i].b1, vecs[i].b2, vecs[i].b3);
      sb.push_back(vecs[i].exp);
      r0 = rdone_cnt;
      pulse_renable();
      wait_drain("tbl_drain", 400);
      repeat (10) tick();
      chk("tbl_rdone_once", rdone_cnt - r0, 32'h1);
      chk("tbl_rdata_hold", rdata, vecs[i].exp);
    end
    slow = 1'b0;

    // renable before any data, held high through the wait.
    r0 = rdone_cnt;
    renable = 1'b1;
    repeat (5) tick();
    chk("empty_no_rdone", rdone_cnt - r0, 32'h0);
    offer(8'hEF, 8'hBE, 8'hAD, 8'hDE);
    sb.push_back(32'hDEAD_BEEF);
    n = 0;
    while (!rdone && n < 200) begin
      tick();
      n++;
    end
    renable = 1'b0;
    chk("held_rdone_seen", {31'b0, rdone}, 32'h1);
    chk("held_rdata", rdata, 32'hDEAD_BEEF);
    repeat (20) tick();
    chk("held_rdone_once", rdone_cnt - r0, 32'h1);
    chk("held_latency", rdone_cyc - last_data_cyc, 32'h1);

    // Status polls with nothing in the UART, then one errored status read.
    s0 = stat_reads;
    d0 = data_reads;
    r0 = rdone_cnt;
    n = 0;
    while (stat_reads - s0 < 10 && n < 300) begin
      tick();
      n++;
    end
    chk("idle_ten_polls", {31'b0, (stat_reads - s0) >= 10}, 32'h1);
    chk("idle_no_data_reads", data_reads - d0, 32'h0);
    chk("idle_no_rdone", rdone_cnt - r0, 32'h0);
    stat_err = 1;
    after_err_gap = -1;
    offer(8'h0D, 8'hF0, 8'hAD, 8'h0B);
    sb.push_back(32'h0BAD_F00D);
    pulse_renable();
    wait_drain("stat_err_drain", 400);
    chk("stat_err_consumed", stat_err, 32'h0);
    chk("stat_err_reissue_addr", after_err_addr, 32'h8);
    chk("stat_err_reissue_gap", after_err_gap, 32'h1);

    // Fill the word FIFO with the core idle; polling must stop at DEPTH words.
    r0 = rdone_cnt;
    for (int i = 0; i < 5; i++) begin
      w = '0;
      for (int j = 0; j < 4; j++) begin
        bv = 8'(8'h40 + i * 16 + j);
        rx_bytes.push_back(bv);
        w = w | (32'(bv) << (8 * j));
      end
      sb.push_back(w);
    end
    n = 0;
    while (rx_bytes.size() > 4 && n < 1000) begin
      tick();
      n++;
    end
    chk("fill_bytes_taken", rx_bytes.size(), 32'h4);
    a0 = arvalid_cnt;
    repeat (30) tick();
    chk("fill_polling_stopped", arvalid_cnt - a0, 32'h0);
    chk("fill_bytes_left", rx_bytes.size(), 32'h4);
    chk("fill_no_rdone", rdone_cnt - r0, 32'h0);
    for (int k = 0; k < DEPTH + 1; k++) begin
      r1 = rdone_cnt;
      pulse_renable();
      n = 0;
      while (rdone_cnt == r1 && n < 300) begin
        tick();
        n++;
      end
      chk("fill_pop_rdone", rdone_cnt - r1, 32'h1);
    end
    chk("fill_sb_empty", sb.size(), 32'h0);
    chk("fill_bytes_all", rx_bytes.size(), 32'h0);

    // Errored DATA read is retried and the byte counted once.
    d0 = data_reads;
    ok0 = data_ok;
    data_err = 1;
    offer(8'h42, 8'hEE, 8'hFF, 8'hC0);
    sb.push_back(32'hC0FF_EE42);
    pulse_renable();
    wait_drain("data_err_drain", 400);
    chk("data_err_reads", data_reads - d0, 32'h5);
    chk("data_err_bytes", data_ok - ok0, 32'h4);
    chk("data_err_consumed", data_err, 32'h0);

    // Reset after a partial word; the next four bytes must form a clean word.
    rx_bytes.push_back(8'h11);
    rx_bytes.push_back(8'h22);
    n = 0;
    while (rx_bytes.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("partial_taken", rx_bytes.size(), 32'h0);
    repeat (3) tick();
    rstn = 1'b0;
    tick();
    tick();
    chk_reset_outputs("midreset");
    rstn = 1'b1;
    offer(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    sb.push_back(32'hDDCC_BBAA);
    pulse_renable();
    wait_drain("post_reset_drain", 400);
    repeat (5) tick();
    chk("post_reset_rdata", rdata, 32'hDDCC_BBAA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
